// File: rtl/sparse_poly_mult_core.sv
// rtl/sparse_poly_mult_core.sv - sparse x dense GF(2) polynomial multiply into an unreduced result RAM
// Optional DUMMY_INSERT_EN: always run MAX_WEIGHT slots, padding with write-back-only dummy slots.
module sparse_poly_mult_core #(
  parameter int N              = 17669,
  parameter int WEIGHT         = 66,
  parameter int MAX_WEIGHT     = 75,
  parameter int RAMWIDTH       = 32,
  parameter int LOGW           = $clog2(N + 1),
  parameter int LOG_MAX_WEIGHT = $clog2(MAX_WEIGHT),
  parameter int D_WORDS        = (N + RAMWIDTH - 1) / RAMWIDTH,
  parameter int RES_WORDS      = 2 * D_WORDS,
  parameter int DADDR_W        = $clog2(D_WORDS),
  parameter int RADDR_W        = $clog2(RES_WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [LOG_MAX_WEIGHT:0]   weight_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [LOG_MAX_WEIGHT-1:0] pos_addr_o,
  input  logic [LOGW-1:0]           pos_data_i,
  output logic [DADDR_W-1:0]        dense_addr_o,
  input  logic [RAMWIDTH-1:0]       dense_data_i,
  output logic [RADDR_W-1:0]        res_addr_o,
  output logic                      res_we_o,
  output logic [RAMWIDTH-1:0]       res_wdata_o,
  input  logic [RAMWIDTH-1:0]       res_rdata_i
);
  localparam int SHW = $clog2(RAMWIDTH);
  localparam int CW  = RADDR_W + 1;
  localparam int WW  = LOG_MAX_WEIGHT + 1;

  if (WEIGHT > MAX_WEIGHT) begin : g_weight_check
    $error("WEIGHT exceeds MAX_WEIGHT");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_POS, S_GET_POS, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [WW-1:0]       s_q, k, slots, w_clamp;
  logic [RADDR_W-1:0]  off;
  logic [SHW-1:0]      bsh;
  logic                slot_ok, slot_dummy, err_q, done_q, pos_ok, wr_phase;
  logic [RAMWIDTH-1:0] d_prev, d_cur;
  logic [2*RAMWIDTH-1:0] cat;

  assign w_clamp = (weight_i > WW'(MAX_WEIGHT)) ? WW'(MAX_WEIGHT) : weight_i;
  assign pos_ok  = pos_data_i < LOGW'(N);
  assign done_o  = done_q;
  assign err_o   = err_q;
`ifdef DUMMY_INSERT_EN
  logic slot_real;
  assign slot_real = k < s_q;
  assign slots     = WW'(MAX_WEIGHT);
`else
  assign slots     = s_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; s_q <= '0; k <= '0; off <= '0; bsh <= '0;
      slot_ok <= 1'b0; slot_dummy <= 1'b0; err_q <= 1'b0; done_q <= 1'b0;
      d_prev <= '0;
    end else begin
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: if (start_i) begin
          s_q <= w_clamp; err_q <= 1'b0; cnt <= '0; k <= '0;
        end
        S_CLEAR: cnt <= cnt + CW'(1);
        S_GET_POS: begin
          cnt    <= '0;
          d_prev <= '0;
          bsh    <= pos_data_i[SHW-1:0];
          off    <= pos_ok ? RADDR_W'(pos_data_i >> SHW) : '0;
`ifdef DUMMY_INSERT_EN
          slot_ok    <= slot_real && pos_ok;
          slot_dummy <= !slot_real;
          if (slot_real && !pos_ok) err_q <= 1'b1;
`else
          slot_ok    <= pos_ok;
          slot_dummy <= 1'b0;
          if (!pos_ok) err_q <= 1'b1;
`endif
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          // word j-1 is consumed in cycle j; keep it as the carry source for word j
          if (cnt != '0) d_prev <= dense_data_i;
        end
        S_DRAIN: k <= k + WW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    busy_o       = (state != S_IDLE);
    pos_addr_o   = '0;
    dense_addr_o = '0;
    res_addr_o   = '0;
    res_we_o     = 1'b0;
    res_wdata_o  = '0;
    wr_phase     = ((state == S_RUN) && (cnt != '0)) || (state == S_DRAIN);
    d_cur        = (state == S_DRAIN) ? '0 : dense_data_i;
    cat          = {d_cur, d_prev} << bsh;
    case (state)
      S_IDLE: if (start_i) state_nx = S_CLEAR;
      S_CLEAR: begin
        // RAM writes land on the previous cycle's address, so issue one ahead
        res_we_o   = 1'b1;
        res_addr_o = RADDR_W'(cnt + CW'(1));
        if (cnt == CW'(RES_WORDS - 1))
          state_nx = (slots == '0) ? S_DONE : S_LOAD_POS;
      end
      S_LOAD_POS: begin
        pos_addr_o = k[LOG_MAX_WEIGHT-1:0];
        state_nx   = S_GET_POS;
      end
      S_GET_POS: state_nx = S_RUN;
      S_RUN: begin
        dense_addr_o = DADDR_W'(cnt);
        res_addr_o   = RADDR_W'(CW'(off) + cnt);
        if (cnt == CW'(D_WORDS)) state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = (k == slots - WW'(1)) ? S_DONE : S_LOAD_POS;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (wr_phase && (slot_ok || slot_dummy)) begin
      res_we_o    = 1'b1;
      res_wdata_o = slot_ok ? (res_rdata_i ^ cat[2*RAMWIDTH-1 -: RAMWIDTH]) : res_rdata_i;
    end
  end
endmodule

// File: tb/tb_sparse_poly_mult_core.sv
// tb/tb_sparse_poly_mult_core.sv - directed self-checking bench for sparse_poly_mult_core (N=64, MAX_WEIGHT=4)
module tb_sparse_poly_mult_core;
  localparam int NB = 64, MW = 4, D = 2, RES = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [2:0]  weight_i = '0;
  logic        busy_o, done_o, err_o, dense_addr_o, res_we_o;
  logic [1:0]  pos_addr_o, res_addr_o;
  logic [6:0]  pos_data_i;
  logic [31:0] dense_data_i, res_wdata_o, res_rdata_i;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sparse_poly_mult_core #(.N(NB), .WEIGHT(2), .MAX_WEIGHT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .weight_i(weight_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .pos_addr_o(pos_addr_o), .pos_data_i(pos_data_i),
    .dense_addr_o(dense_addr_o), .dense_data_i(dense_data_i),
    .res_addr_o(res_addr_o), .res_we_o(res_we_o),
    .res_wdata_o(res_wdata_o), .res_rdata_i(res_rdata_i)
  );

  // RAMs register their address; reads and writes both use that registered address
  logic [6:0]  pos_mem [4];
  logic [31:0] dense_mem [2];
  logic [31:0] res_mem [4];
  logic [1:0]  pos_aq = '0, res_aq = '0;
  logic        dense_aq = 1'b0;

  always @(posedge clk) begin
    pos_aq   <= pos_addr_o;
    dense_aq <= dense_addr_o;
    res_aq   <= res_addr_o;
    if (res_we_o) res_mem[res_aq] <= res_wdata_o;
  end
  assign pos_data_i   = pos_mem[pos_aq];
  assign dense_data_i = dense_mem[dense_aq];
  assign res_rdata_i  = res_mem[res_aq];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int slots_of(input int w);
`ifdef DUMMY_INSERT_EN
    return MW;
`else
    return (w > MW) ? MW : w;
`endif
  endfunction

  function automatic int lat_of(input int w);
    return 1 + RES + slots_of(w) * (D + 4);
  endfunction

  // GF(2) product of the first S valid positions with the 64-bit dense polynomial
  function automatic logic [127:0] model_prod(input int w);
    logic [127:0] r = '0;
    int s = (w > MW) ? MW : w;
    for (int i = 0; i < s; i++)
      if (pos_mem[i] < NB) r ^= {64'd0, dense_mem[1], dense_mem[0]} << pos_mem[i];
    return r;
  endfunction

  function automatic logic model_err(input int w);
    logic e = 1'b0;
    int s = (w > MW) ? MW : w;
    for (int i = 0; i < s; i++) if (pos_mem[i] >= NB) e = 1'b1;
    return e;
  endfunction

  task automatic load(input int p0, p1, p2, p3, input logic [31:0] d0, d1);
    pos_mem[0] = 7'(p0); pos_mem[1] = 7'(p1); pos_mem[2] = 7'(p2); pos_mem[3] = 7'(p3);
    dense_mem[0] = d0; dense_mem[1] = d1;
  endtask

  task automatic run_op(input string nm, input int w, input int lat, input bit use_lit,
                        input logic [127:0] lit, input bit lit_err, input bit poke);
    logic [127:0] exp_r;
    logic         exp_e;
    exp_r = model_prod(w);
    exp_e = model_err(w);
    if (use_lit) begin
      check({nm, "_model_pin"}, exp_r, lit);
      check({nm, "_model_err_pin"}, 128'(exp_e), 128'(lit_err));
    end
    @(negedge clk);
    start_i = 1'b1; weight_i = 3'(w);
    @(posedge clk);
    #1 start_i = 1'b0; weight_i = 3'($urandom);
    for (int t = 0; t <= lat; t++) begin
      @(negedge clk);
      check({nm, "_busy"}, 128'(busy_o), 128'(t < lat));
      check({nm, "_done"}, 128'(done_o), 128'(t == lat));
      if (t == 0) check({nm, "_err_clr"}, 128'(err_o), 128'(0));
      if (poke && t == 1) begin start_i = 1'b1; weight_i = 3'd4; end
      if (poke && t == 2) start_i = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_res%0d", nm, i), 128'(res_mem[i]), 128'(exp_r[32*i +: 32]));
    check({nm, "_err"}, 128'(err_o), 128'(exp_e));
  endtask

  initial begin
    load(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy_o, done_o, err_o, res_we_o, res_wdata_o, res_addr_o, pos_addr_o, dense_addr_o},
          '0);
    @(negedge clk) rst_n = 1'b1;

`ifdef DUMMY_INSERT_EN
    load(0, 0, 0, 0, 32'h00000001, 32'h80000000);
    run_op("t1", 1, 29, 1, {32'h0, 32'h0, 32'h80000000, 32'h00000001}, 1'b0, 1'b0);
    load(33, 0, 0, 0, 32'hFFFFFFFF, 32'h0);
    run_op("t2", 3, 29, 0, '0, 1'b0, 1'b0);
`else
    load(0, 0, 0, 0, 32'h00000001, 32'h80000000);
    run_op("t1", 1, 11, 1, {32'h0, 32'h0, 32'h80000000, 32'h00000001}, 1'b0, 1'b0);
`endif
    load(33, 0, 0, 0, 32'hFFFFFFFF, 32'h0);
    run_op("t2", 1, lat_of(1), 1, {32'h0, 32'h00000001, 32'hFFFFFFFE, 32'h0}, 1'b0, 1'b0);
    load(5, 5, 0, 0, 32'h12345678, 32'h9ABCDEF0);
    run_op("t3", 2, lat_of(2), 1, '0, 1'b0, 1'b0);
    load(1, 40, 63, 0, 32'hDEADBEEF, 32'h0F0F0F0F);
    run_op("mix3", 3, lat_of(3), 0, '0, 1'b0, 1'b0);
`ifdef DUMMY_INSERT_EN
    run_op("t4", 0, 29, 1, '0, 1'b0, 1'b1);
`else
    run_op("t4", 0, 5, 1, '0, 1'b0, 1'b1);
`endif
    load(63, 0, 17, 9, 32'h80000001, 32'hC0000003);
    run_op("mix2", 2, lat_of(2), 0, '0, 1'b0, 1'b0);
    load(64, 0, 0, 0, 32'hCAFEF00D, 32'h12345678);
    run_op("t5", 1, lat_of(1), 1, '0, 1'b1, 1'b0);
    load(7, 0, 0, 0, 32'h00000001, 32'h00000002);
    run_op("t6", 1, lat_of(1), 1, {32'h0, 32'h0, 32'h00000100, 32'h00000080}, 1'b0, 1'b0);
    load(2, 3, 60, 17, 32'hAAAA5555, 32'h0000FFFF);
    run_op("clamp", 7, lat_of(7), 0, '0, 1'b0, 1'b0);

    load(10, 0, 0, 0, 32'h0000000F, 32'h0);
    @(negedge clk);
    start_i = 1'b1; weight_i = 3'd1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int t = 0; t <= 7; t++) @(negedge clk);
    check("rst_pre_we", 128'(res_we_o), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_we", 128'(res_we_o), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_done", 128'({done_o, busy_o}), 128'(0));

    load(20, 0, 0, 0, 32'h00000003, 32'h80000000);
    run_op("post_rst", 1, lat_of(1), 0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sparse_poly_mult_core.md
Name: sparse_poly_mult_core

Overview:
Downstream compute stage of the position/random-bits loader. Once loading completes, it multiplies a sparse GF(2) polynomial by a dense GF(2) polynomial. The sparse polynomial is a list of bit positions in the position RAM; the dense polynomial is 32-bit words in the random-bits RAM. The product is written unreduced (2N-bit span) into a result RAM by word-level shift-XOR read-modify-write, which the host later reads back.

Parameters:
N, 17669, polynomial length in bits
WEIGHT, 66, nominal sparse weight
MAX_WEIGHT, 75, maximum weight and position RAM depth
RAMWIDTH, 32, word width of dense and result RAMs
LOGW, derived, width of one position entry
LOG_MAX_WEIGHT, derived, width of weight and position address
D_WORDS, ceil(N/RAMWIDTH) = 553, number of dense words
RES_WORDS, 2*D_WORDS = 1106, number of result words
DADDR_W / RADDR_W, derived, clog2 of D_WORDS / RES_WORDS

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  start request, sampled only in IDLE
weight_i  in  LOG_MAX_WEIGHT+1  number of valid positions, sampled with start_i
busy_o  out  1  high from the cycle after start is accepted until done_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky: a position >= N was seen; cleared by the next accepted start
pos_addr_o  out  LOG_MAX_WEIGHT  position RAM read address
pos_data_i  in  LOGW  position RAM data, one-cycle read latency
dense_addr_o  out  DADDR_W  dense RAM read address
dense_data_i  in  RAMWIDTH  dense RAM data, one-cycle latency
res_addr_o  out  RADDR_W  result RAM address, shared by read and write
res_we_o  out  1  result write enable
res_wdata_o  out  RAMWIDTH  result write data
res_rdata_i  in  RAMWIDTH  result read data, one-cycle latency

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-operation aborts immediately and returns to IDLE; result RAM contents are undefined.
- Weight handling: S = min(weight_i, MAX_WEIGHT). start_i while busy is ignored.
- FSM states, in order: IDLE -> CLEAR -> LOAD_POS -> GET_POS -> RUN -> DRAIN -> (next slot: LOAD_POS | last slot: DONE) -> IDLE.
- CLEAR: RES_WORDS cycles writing 0 to result addresses 0..RES_WORDS-1. If S = 0, go straight from CLEAR to DONE.
- LOAD_POS: drive pos_addr_o = k, the slot index.
- GET_POS: capture p = pos_data_i, off = p >> 5, b = p & 31.
- Invalid position: if p >= N, the slot becomes a no-op and err_o is set. The slot still walks RUN with res_we_o held low, so timing is unchanged.
- RUN: D_WORDS+1 cycles, j = 0..D_WORDS.
  - Each cycle issues dense_addr_o = j (don't-care when j = D_WORDS) and res_addr_o = off+j.
  - One cycle later: res_wdata_o = res_rdata_i ^ s_j and res_we_o = 1, written to the registered address off+j.
  - s_j = (d_j << b) | (b ? d_{j-1} >> (32-b) : 0), with d_{-1} = 0 and d_{D_WORDS} = 0. d_{j-1} is held in a register from the prior cycle.
  - Issue and write overlap; addresses within one slot are distinct, so there is no hazard.
- DRAIN: 1 cycle, performs the final write.
- Per-slot cost: D_WORDS+4 cycles. Slots never overlap.
- Range: max target address is (D_WORDS-1) + D_WORDS = RES_WORDS-1, always in range.
- Latency: done_o is high exactly 1 + RES_WORDS + S*(D_WORDS+4) cycles after the edge that samples start_i. busy_o falls with done_o.

Optional Feature:
DUMMY_INSERT_EN.
- Defined: the core always processes MAX_WEIGHT slots.
- Slots k >= S run the full LOAD_POS/GET_POS/RUN/DRAIN sequence with res_we_o = 1, but res_wdata_o = res_rdata_i (unchanged write-back).
- Latency is then 1 + RES_WORDS + MAX_WEIGHT*(D_WORDS+4), independent of weight.
- Dummy slots never set err_o.
- Undefined: only S slots are processed.

Test Plan:
Bench overrides N=64 (D_WORDS=2, RES_WORDS=4), MAX_WEIGHT=4.
- weight=1, pos[0]=0, dense=[0x00000001,0x80000000] -> result=[0x00000001,0x80000000,0,0]; done_o 11 cycles after start.
- weight=1, pos[0]=33, dense=[0xFFFFFFFF,0] -> result=[0,0xFFFFFFFE,0x00000001,0].
- weight=2, pos=[5,5], any dense -> result all 0 (XOR cancellation); done_o at cycle 17.
- weight=0 -> result all 0, done_o at cycle 5; start_i pulsed during CLEAR is ignored.
- weight=1, pos[0]=64 -> err_o=1, result all 0; err_o clears on the next start. Separately: rst_n low mid-RUN -> busy_o=0 and res_we_o=0 immediately.
- With DUMMY_INSERT_EN: weight=1 and weight=3 both finish at cycle 29, and results match the non-dummy reference model.
